// File: rtl/activation_output_writer.sv
// activation_output_writer
//
// Takes the per-lane requantized int8 stream that leaves the systolic array and
// writes it into the activation SRAM for the next layer. Every lane has its own
// small FIFO. A round-robin arbiter picks one lane head per cycle, then gathers
// every other lane head with the same (row, col) so that one byte-enabled SRAM
// word write covers all of them. A start/flush FSM frames each layer pass.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             pulse, latches cfg_* and begins a pass (IDLE only)
//   flush             pulse, last lane sample of the pass has been presented
//   cfg_base          base word address of the output tensor
//   cfg_width         output columns per row
//   cfg_groups        channel groups per pixel
//   cfg_group         channel group handled by this pass
//   in_valid          per-lane sample valid
//   in_row, in_col    per-lane coordinates, lane k at [k*N_BITS +: N_BITS]
//   in_data           per-lane int8 value, lane k at [k*8 +: 8]
//   mem_we            SRAM write request, held until mem_ready
//   mem_ready         SRAM accepts the write this cycle
//   mem_addr          SRAM word address
//   mem_wdata         byte k carries lane k data
//   mem_byte_en       byte k enabled when lane k joined the write
//   idle              IDLE, all FIFOs empty and no write outstanding
//   done              one-cycle pulse on the DRAIN to IDLE transition
//   err_overflow      sticky, a lane sample was dropped
module activation_output_writer #(
  parameter int SA_N       = 4,
  parameter int MAX_N      = 64,
  parameter int N_BITS     = $clog2(MAX_N),
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int GROUP_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     flush,
  input  logic [ADDR_WIDTH-1:0]    cfg_base,
  input  logic [N_BITS:0]          cfg_width,
  input  logic [GROUP_BITS:0]      cfg_groups,
  input  logic [GROUP_BITS-1:0]    cfg_group,
  input  logic [SA_N-1:0]          in_valid,
  input  logic [SA_N*N_BITS-1:0]   in_row,
  input  logic [SA_N*N_BITS-1:0]   in_col,
  input  logic [SA_N*8-1:0]        in_data,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [SA_N*8-1:0]        mem_wdata,
  output logic [SA_N-1:0]          mem_byte_en,
  output logic                     idle,
  output logic                     done,
  output logic                     err_overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int RR_W    = (SA_N > 1) ? $clog2(SA_N) : 1;
  localparam int ENTRY_W = 2 * N_BITS + 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [N_BITS:0]       width_q;
  logic [GROUP_BITS:0]   groups_q;
  logic [GROUP_BITS-1:0] group_q;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [ENTRY_W-1:0] fifo_mem [SA_N][FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr   [SA_N];
  logic [PTR_W:0]     rd_ptr   [SA_N];

  logic [SA_N-1:0]    lane_empty;
  logic [SA_N-1:0]    lane_full;
  logic [N_BITS-1:0]  head_row  [SA_N];
  logic [N_BITS-1:0]  head_col  [SA_N];
  logic [7:0]         head_data [SA_N];
  logic               all_empty;

  logic [RR_W-1:0]    rr;
  logic [RR_W-1:0]    winner;
  logic [RR_W-1:0]    rr_after;
  logic               any_head;
  logic [SA_N-1:0]    merge;
  logic [N_BITS-1:0]  win_row;
  logic [N_BITS-1:0]  win_col;
  logic [SA_N*8-1:0]  wdata_next;
  logic [ADDR_WIDTH-1:0] addr_next;

  logic               load;
  logic [SA_N-1:0]    pop;
  logic [SA_N-1:0]    push;
  logic               drop;

  always_comb begin
    for (int k = 0; k < SA_N; k++) begin
      lane_empty[k] = (wr_ptr[k] == rd_ptr[k]);
      lane_full[k]  = (wr_ptr[k][PTR_W] != rd_ptr[k][PTR_W]) &&
                      (wr_ptr[k][PTR_W-1:0] == rd_ptr[k][PTR_W-1:0]);
      {head_row[k], head_col[k], head_data[k]} = fifo_mem[k][rd_ptr[k][PTR_W-1:0]];
    end
  end

  assign all_empty = &lane_empty;

  // Round-robin winner is the first non-empty lane at or after rr. Every other
  // non-empty lane whose head points at the same pixel rides along in the
  // same SRAM word, each in its own byte.
  always_comb begin
    int idx;
    idx        = 0;
    any_head   = 1'b0;
    winner     = '0;
    merge      = '0;
    wdata_next = '0;
    for (int i = 0; i < SA_N; i++) begin
      idx = int'(rr) + i;
      if (idx >= SA_N) idx = idx - SA_N;
      if (!any_head && !lane_empty[idx]) begin
        winner   = RR_W'(idx);
        any_head = 1'b1;
      end
    end
    win_row = head_row[winner];
    win_col = head_col[winner];
    for (int k = 0; k < SA_N; k++) begin
      if (!lane_empty[k] && head_row[k] == win_row && head_col[k] == win_col) begin
        merge[k]              = 1'b1;
        wdata_next[k*8 +: 8]  = head_data[k];
      end
    end
  end

  assign rr_after = (winner == RR_W'(SA_N - 1)) ? '0 : winner + RR_W'(1);

  // Arithmetic is done at ADDR_WIDTH so the result wraps modulo the address space.
  assign addr_next = base_q +
                     (ADDR_WIDTH'(win_row) * ADDR_WIDTH'(width_q) + ADDR_WIDTH'(win_col)) *
                     ADDR_WIDTH'(groups_q) + ADDR_WIDTH'(group_q);

  // A new word may only replace the write register when it is empty or its
  // current word is being taken by the SRAM this very cycle. A full lane FIFO
  // still accepts a push when its head pops in the same cycle.
  always_comb begin
    load = (state != IDLE) && any_head && (!mem_we || mem_ready);
    pop  = load ? merge : '0;
    for (int k = 0; k < SA_N; k++) begin
      push[k] = (state == RUN) && in_valid[k] && (!lane_full[k] || pop[k]);
    end
    drop = |(in_valid & ~push);
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (flush) state_next = DRAIN;
      DRAIN: begin
        if (all_empty && !mem_we) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign idle = (state == IDLE) && all_empty && !mem_we;

  // Error flag: a drop in the same cycle as an accepted start still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr           <= '0;
      err_overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (load) rr <= rr_after;
      if (drop) err_overflow <= 1'b1;
      else if (state == IDLE && start) err_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q   <= '0;
      width_q  <= '0;
      groups_q <= '0;
      group_q  <= '0;
    end else if (state == IDLE && start) begin
      base_q   <= cfg_base;
      width_q  <= cfg_width;
      groups_q <= cfg_groups;
      group_q  <= cfg_group;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SA_N; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SA_N; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + (PTR_W+1)'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + (PTR_W+1)'(1);
      end
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < SA_N; k++) begin
      if (push[k]) begin
        fifo_mem[k][wr_ptr[k][PTR_W-1:0]] <= {in_row[k*N_BITS +: N_BITS],
                                              in_col[k*N_BITS +: N_BITS],
                                              in_data[k*8 +: 8]};
      end
    end
  end

  // The write register holds every output steady while the SRAM stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_byte_en <= '0;
    end else if (load) begin
      mem_we      <= 1'b1;
      mem_addr    <= addr_next;
      mem_wdata   <= wdata_next;
      mem_byte_en <= merge;
    end else if (mem_ready) begin
      mem_we      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_activation_output_writer.sv
// Testbench for activation_output_writer: directed pass scenarios with
// hand-computed expectations followed by randomized passes, all checked every
// cycle against a queue-based behavioural model.
module tb_activation_output_writer;

  localparam int SA_N       = 4;
  localparam int FIFO_DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [15:0] cfg_base;
  logic [6:0]  cfg_width;
  logic [4:0]  cfg_groups;
  logic [3:0]  cfg_group;
  logic [3:0]  in_valid;
  logic [23:0] in_row;
  logic [23:0] in_col;
  logic [31:0] in_data;
  logic        mem_we;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        idle;
  logic        done;
  logic        err_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  activation_output_writer dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .cfg_base(cfg_base), .cfg_width(cfg_width), .cfg_groups(cfg_groups),
    .cfg_group(cfg_group), .in_valid(in_valid), .in_row(in_row),
    .in_col(in_col), .in_data(in_data), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte_en(mem_byte_en), .idle(idle), .done(done),
    .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: lane FIFOs are plain queues, the pass is a mode number
  // (0 idle, 1 run, 2 drain), and the pending SRAM word is a single record.
  typedef struct packed {
    logic [5:0] row;
    logic [5:0] col;
    logic [7:0] data;
  } samp_t;

  samp_t       mq [SA_N][$];
  int          m_mode = 0;
  int          m_rr   = 0;
  bit          m_err  = 0;
  int          m_base = 0, m_width = 0, m_groups = 0, m_group = 0;
  bit          w_valid = 0;
  logic [15:0] w_addr  = '0;
  logic [31:0] w_data  = '0;
  logic [3:0]  w_be    = '0;

  function automatic bit modelAllEmpty();
    for (int k = 0; k < SA_N; k++) if (mq[k].size() != 0) return 0;
    return 1;
  endfunction

  task automatic modelStep();
    samp_t       h, s;
    int          win, cur_mode, na;
    bit          found, load, fin;
    logic [3:0]  mset;
    logic [31:0] nd;
    if (reset) begin
      for (int k = 0; k < SA_N; k++) mq[k].delete();
      m_rr = 0; m_mode = 0; m_err = 0;
      w_valid = 0; w_addr = '0; w_data = '0; w_be = '0;
      return;
    end
    cur_mode = m_mode;
    fin      = (cur_mode == 2) && modelAllEmpty() && !w_valid;
    found = 0; load = 0; win = 0; mset = '0; nd = '0; na = 0;
    if (cur_mode != 0) begin
      for (int i = 0; i < SA_N; i++) begin
        if (!found && mq[(m_rr + i) % SA_N].size() > 0) begin
          win = (m_rr + i) % SA_N; found = 1;
        end
      end
    end
    if (found && (!w_valid || mem_ready)) begin
      load = 1;
      h = mq[win][0];
      for (int k = 0; k < SA_N; k++) begin
        if (mq[k].size() > 0 && mq[k][0].row == h.row && mq[k][0].col == h.col) begin
          mset[k] = 1'b1;
          nd[k*8 +: 8] = mq[k][0].data;
        end
      end
      na = (m_base + (int'(h.row) * m_width + int'(h.col)) * m_groups + m_group) % 65536;
      for (int k = 0; k < SA_N; k++) if (mset[k]) void'(mq[k].pop_front());
      m_rr = (win + 1) % SA_N;
    end
    if (cur_mode == 0 && start) begin
      m_base = int'(cfg_base); m_width = int'(cfg_width);
      m_groups = int'(cfg_groups); m_group = int'(cfg_group);
      m_err = 0; m_mode = 1;
    end
    for (int k = 0; k < SA_N; k++) begin
      if (in_valid[k]) begin
        if (cur_mode == 1 && mq[k].size() < FIFO_DEPTH) begin
          s.row = in_row[k*6 +: 6]; s.col = in_col[k*6 +: 6]; s.data = in_data[k*8 +: 8];
          mq[k].push_back(s);
        end else begin
          m_err = 1;
        end
      end
    end
    if (cur_mode == 1 && flush) m_mode = 2;
    if (fin) m_mode = 0;
    if (load) begin
      w_valid = 1; w_addr = 16'(na); w_data = nd; w_be = mset;
    end else if (w_valid && mem_ready) begin
      w_valid = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every output is compared with the model on the falling edge of each cycle.
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      checkOutput("model_mem_we",      64'(mem_we),       64'(w_valid));
      checkOutput("model_mem_addr",    64'(mem_addr),     64'(w_addr));
      checkOutput("model_mem_wdata",   64'(mem_wdata),    64'(w_data));
      checkOutput("model_mem_byte_en", 64'(mem_byte_en),  64'(w_be));
      checkOutput("model_idle",        64'(idle),  64'(m_mode == 0 && modelAllEmpty() && !w_valid));
      checkOutput("model_done",        64'(done),  64'(m_mode == 2 && modelAllEmpty() && !w_valid));
      checkOutput("model_err",         64'(err_overflow), 64'(m_err));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic atNeg();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [23:0] rows,
                               input logic [23:0] cols, input logic [31:0] dat);
    in_valid = v; in_row = rows; in_col = cols; in_data = dat;
  endtask

  task automatic pushLane0(input int col, input int dat);
    applyStimulus(4'b0001, 24'd0, 24'(col), 32'(dat));
  endtask

  task automatic applyReset();
    applyStimulus(4'b0, 24'd0, 24'd0, 32'd0);
    start = 0; flush = 0; reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic startPass(input logic [15:0] b, input logic [6:0] w,
                           input logic [4:0] g, input logic [3:0] gi);
    applyStimulus(4'b0, 24'd0, 24'd0, 32'd0);
    cfg_base = b; cfg_width = w; cfg_groups = g; cfg_group = gi;
    start = 1;
    tick();
    start = 0;
  endtask

  logic [5:0] pr0, pr1, pc0, pc1;

  task automatic randomCycle(input bit allow_valid);
    logic [23:0] r, c;
    r = '0; c = '0;
    for (int k = 0; k < SA_N; k++) begin
      r[k*6 +: 6] = ($urandom_range(0, 1) == 0) ? pr0 : pr1;
      c[k*6 +: 6] = ($urandom_range(0, 1) == 0) ? pc0 : pc1;
    end
    applyStimulus(allow_valid ? 4'($urandom_range(0, 15)) : 4'b0, r, c, $urandom);
    mem_ready  = ($urandom_range(0, 3) != 0);
    cfg_base   = 16'($urandom);
    cfg_width  = 7'($urandom);
    cfg_groups = 5'($urandom);
    cfg_group  = 4'($urandom);
  endtask

  initial begin
    bit done_seen;
    int len;
    reset = 1; start = 0; flush = 0; mem_ready = 1;
    cfg_base = 16'h100; cfg_width = 7'd8; cfg_groups = 5'd2; cfg_group = 4'd1;
    applyStimulus(4'b0, 24'd0, 24'd0, 32'd0);
    tick();
    check_en = 1;
    atNeg();
    checkOutput("reset_mem_we", 64'(mem_we), 64'd0);
    checkOutput("reset_idle", 64'(idle), 64'd1);
    checkOutput("reset_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("reset_byte_en", 64'(mem_byte_en), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_err", 64'(err_overflow), 64'd0);
    tick();
    reset = 0;

    // Coalesce: four lanes on one pixel become a single full word.
    startPass(16'h100, 7'd8, 5'd2, 4'd1);
    atNeg();
    checkOutput("idle_after_start", 64'(idle), 64'd0);
    applyStimulus(4'hf, {4{6'd2}}, {4{6'd3}}, 32'h04030201);
    tick();
    applyStimulus(4'b0, 24'd0, 24'd0, 32'd0);
    atNeg();
    checkOutput("coal_we_n1", 64'(mem_we), 64'd0);
    tick();
    atNeg();
    checkOutput("coal_we_n2", 64'(mem_we), 64'd1);
    checkOutput("coal_addr", 64'(mem_addr), 64'h127);
    checkOutput("coal_byte_en", 64'(mem_byte_en), 64'hf);
    checkOutput("coal_wdata", 64'(mem_wdata), 64'h04030201);
    tick();
    atNeg();
    checkOutput("coal_we_after", 64'(mem_we), 64'd0);

    // Split: different pixels go out separately, round-robin order.
    applyReset();
    startPass(16'h100, 7'd8, 5'd2, 4'd1);
    applyStimulus(4'b0101, 24'd0, {6'd0, 6'd1, 6'd0, 6'd0}, 32'h00220011);
    tick();
    applyStimulus(4'b0, 24'd0, 24'd0, 32'd0);
    tick();
    atNeg();
    checkOutput("split_be0", 64'(mem_byte_en), 64'b0001);
    checkOutput("split_addr0", 64'(mem_addr), 64'h101);
    checkOutput("split_wdata0", 64'(mem_wdata), 64'h11);
    tick();
    atNeg();
    checkOutput("split_be1", 64'(mem_byte_en), 64'b0100);
    checkOutput("split_addr1", 64'(mem_addr), 64'h103);
    checkOutput("split_wdata1", 64'(mem_wdata), 64'h00220000);
    tick();
    // rr now sits at lane 3, so lane 3 must beat lane 1.
    applyStimulus(4'b1010, {6'd1, 6'd0, 6'd1, 6'd0}, {6'd1, 6'd0, 6'd0, 6'd0}, 32'h44003300);
    tick();
    applyStimulus(4'b0, 24'd0, 24'd0, 32'd0);
    tick();
    atNeg();
    checkOutput("rr_be_first", 64'(mem_byte_en), 64'b1000);
    checkOutput("rr_addr_first", 64'(mem_addr), 64'h113);
    tick();
    atNeg();
    checkOutput("rr_be_second", 64'(mem_byte_en), 64'b0010);
    checkOutput("rr_addr_second", 64'(mem_addr), 64'h111);
    tick();

    // Backpressure: outputs hold, the sixth sample overflows lane 0.
    applyReset();
    startPass(16'h100, 7'd8, 5'd2, 4'd1);
    mem_ready = 0;
    for (int i = 0; i < 6; i++) begin
      pushLane0(i, i + 1);
      if (i >= 2) begin
        atNeg();
        checkOutput("bp_hold_we", 64'(mem_we), 64'd1);
        checkOutput("bp_hold_addr", 64'(mem_addr), 64'h101);
      end
      tick();
    end
    applyStimulus(4'b0, 24'd0, 24'd0, 32'd0);
    atNeg();
    checkOutput("bp_err", 64'(err_overflow), 64'd1);
    checkOutput("bp_addr_s0", 64'(mem_addr), 64'h101);
    mem_ready = 1;
    for (int j = 1; j < 5; j++) begin
      tick();
      atNeg();
      checkOutput("bp_drain_addr", 64'(mem_addr), 64'(16'h101 + 16'(2 * j)));
    end
    tick();
    atNeg();
    checkOutput("bp_we_end", 64'(mem_we), 64'd0);

    // Full lane FIFO popping in the same cycle as a push loses nothing.
    applyReset();
    startPass(16'h100, 7'd8, 5'd2, 4'd1);
    mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      pushLane0(i, 16 + i);
      tick();
    end
    pushLane0(5, 21);
    mem_ready = 1;
    atNeg();
    checkOutput("fp_addr_s0", 64'(mem_addr), 64'h101);
    tick();
    applyStimulus(4'b0, 24'd0, 24'd0, 32'd0);
    atNeg();
    checkOutput("fp_no_drop", 64'(err_overflow), 64'd0);
    checkOutput("fp_addr_s1", 64'(mem_addr), 64'h103);
    for (int j = 2; j < 6; j++) begin
      tick();
      atNeg();
      checkOutput("fp_drain_addr", 64'(mem_addr), 64'(16'h101 + 16'(2 * j)));
    end
    checkOutput("fp_wdata_s5", 64'(mem_wdata), 64'd21);
    tick();
    atNeg();
    checkOutput("fp_we_end", 64'(mem_we), 64'd0);
    checkOutput("fp_err_end", 64'(err_overflow), 64'd0);

    // Flush with samples arriving the same cycle, then drain and done.
    applyReset();
    startPass(16'h100, 7'd8, 5'd2, 4'd1);
    applyStimulus(4'b0111, 24'd0, {6'd0, 6'd2, 6'd1, 6'd0}, 32'h00332211);
    flush = 1;
    tick();
    flush = 0;
    applyStimulus(4'b1000, 24'd0, 24'd0, 32'h99000000);
    atNeg();
    checkOutput("fl_done_c1", 64'(done), 64'd0);
    tick();
    applyStimulus(4'b0, 24'd0, 24'd0, 32'd0);
    atNeg();
    checkOutput("fl_err_drain", 64'(err_overflow), 64'd1);
    checkOutput("fl_be0", 64'(mem_byte_en), 64'b0001);
    tick();
    tick();
    atNeg();
    checkOutput("fl_be2", 64'(mem_byte_en), 64'b0100);
    checkOutput("fl_addr2", 64'(mem_addr), 64'h105);
    tick();
    atNeg();
    checkOutput("fl_done", 64'(done), 64'd1);
    checkOutput("fl_idle_pre", 64'(idle), 64'd0);
    tick();
    atNeg();
    checkOutput("fl_done_off", 64'(done), 64'd0);
    checkOutput("fl_idle", 64'(idle), 64'd1);

    // Reset while a write is stalled abandons it.
    startPass(16'h200, 7'd4, 5'd1, 4'd0);
    mem_ready = 0;
    pushLane0(1, 7);
    tick();
    applyStimulus(4'b0, 24'd0, 24'd0, 32'd0);
    tick();
    atNeg();
    checkOutput("rst_we_before", 64'(mem_we), 64'd1);
    reset = 1;
    tick();
    atNeg();
    checkOutput("rst_we", 64'(mem_we), 64'd0);
    checkOutput("rst_idle", 64'(idle), 64'd1);
    checkOutput("rst_be", 64'(mem_byte_en), 64'd0);
    reset = 0;
    mem_ready = 1;
    for (int j = 0; j < 5; j++) begin
      tick();
      atNeg();
      checkOutput("rst_quiet_we", 64'(mem_we), 64'd0);
    end

    // Randomized passes: pixels drawn from a small set to force merges.
    for (int p = 0; p < 12; p++) begin
      pr0 = 6'($urandom); pr1 = 6'($urandom);
      pc0 = 6'($urandom); pc1 = 6'($urandom);
      startPass(16'($urandom), 7'($urandom_range(1, 64)),
                5'($urandom_range(1, 16)), 4'($urandom_range(0, 15)));
      len = $urandom_range(20, 60);
      for (int c = 0; c < len; c++) begin
        randomCycle(1);
        start = ($urandom_range(0, 15) == 0);
        tick();
      end
      start = 0;
      randomCycle(1);
      flush = 1;
      tick();
      flush = 0;
      done_seen = 0;
      for (int c = 0; c < 300 && !done_seen; c++) begin
        randomCycle($urandom_range(0, 9) == 0);
        atNeg();
        if (done) done_seen = 1;
        tick();
      end
      if (!done_seen) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL drain_timeout: pass %0d got no done, expected done within 300 cycles", p);
      end
      applyStimulus(4'b0, 24'd0, 24'd0, 32'd0);
      mem_ready = 1;
      tick();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
